alu_lockstep_tester: RTL and testbench
======================================

// Module: alu_lockstep_tester
// PURPOSE
//  On-chip stimulus generator and checker for the dual 4-bit lockstep ALU (alu_xor_4).
//  Drives the operand/select bus that the ALU takes from io_in.
//  Samples ALU_Out1/2, CarryOut1/2, x and y, and counts check failures.
//  Lets the macro self-test without an external pattern source.
// PARAMETERS
//  SEED      20'h5A5A5  LFSR start value; SEED==0 is replaced by 20'h00001
//  RESP_LAT  2          cycles operands are held before the response is sampled (>=1)
//  NUM_VEC   256        vectors per run (1..65535)
// PORTS
//  wb_clk_i     in   1   clock
//  wb_rst_n     in   1   reset, asynchronous, active-low
//  start        in   1   begin a run; sampled only in IDLE or DONE
//  lockstep     in   1   1: ALU1 gets the same operands as ALU0; 0: independent operands
//  A0,B0,A1,B1  out  4   operands to the ALU (registered)
//  ALU_Sel1     out  2   select for ALU0 (registered)
//  ALU_Sel2     out  2   select for ALU1 (registered)
//  ALU_Out1     in   4   ALU0 result
//  ALU_Out2     in   4   ALU1 result
//  CarryOut1    in   1   ALU0 carry
//  CarryOut2    in   1   ALU1 carry
//  x            in   4   ALU compare bus, defined as ALU_Out1^ALU_Out2
//  y            in   1   ALU carry compare, defined as CarryOut1^CarryOut2
//  busy         out  1   run in progress
//  done         out  1   run complete; held until the next start
//  pass         out  1   done && err_count==0
//  err_count    out  8   failing vectors, saturates at 8'hFF
//  first_err    out  16  vec_count of the first failing vector; 16'hFFFF if none
//  vec_count    out  16  vectors checked in the current run
// BEHAVIOUR
//  Reset values (asynchronous):
//   - All operand/select outputs 0; busy=done=pass=0; err_count=0.
//   - vec_count=0; first_err=16'hFFFF; LFSR=SEED; FSM in IDLE.
//  LFSR:
//   - 20-bit Fibonacci: next = {l[18:0], l[19]^l[16]}.
//   - Advances once per vector in CHECK; first vector of a run uses SEED.
//  Operand mapping in DRIVE:
//   - A0=l[3:0], B0=l[7:4], A1=l[11:8], B1=l[15:12], Sel1=l[17:16], Sel2=l[19:18].
//   - If lockstep=1: A1=A0, B1=B0, Sel2=Sel1 (lockstep sampled per vector in DRIVE).
//  FSM:
//   - IDLE  -start-> DRIVE; clears counters, sets first_err=FFFF, reloads LFSR=SEED, busy=1.
//   - DRIVE: registers operands; -> WAIT, which counts RESP_LAT cycles.
//   - WAIT  -> CHECK after its last cycle.
//   - CHECK: samples the ALU inputs and evaluates the failures below; vector fails if any is true.
//   - CHECK -> DRIVE if vec_count+1 < NUM_VEC, else -> DONE.
//   - DONE: busy=0, done=1; -start-> same as IDLE -start- (done drops).
//  Failure conditions evaluated in CHECK:
//   - (a) x != ALU_Out1^ALU_Out2
//   - (b) y != CarryOut1^CarryOut2
//   - (c) lockstep=1 && (ALU_Out1!=ALU_Out2 || CarryOut1!=CarryOut2)
//  CHECK updates:
//   - Every vector: vec_count += 1.
//   - On failure: err_count += 1, saturating at FF.
//   - On failure with first_err==FFFF: first_err = pre-increment vec_count.
//  Timing:
//   - Per vector: RESP_LAT+2 cycles (DRIVE + WAIT + CHECK).
//   - Operands stay stable from the DRIVE edge through CHECK.
//   - Outputs hold their last values after the run.
//  Boundary and simultaneous-event rules:
//   - start while busy is ignored.
//   - start in the same cycle as the final CHECK is ignored; the FSM enters DONE.
//   - Reset mid-run aborts immediately to reset values; no partial result is retained.
//   - Register bit 0 of pass with done, so pass never asserts without done.
// TESTING
//  1. Reset with no clock -> all outputs at reset values; first_err=FFFF; operands 0.
//  2. NUM_VEC=4, RESP_LAT=2, lockstep=1, ideal ALU model, start pulse at cycle 0
//     -> done=1 16 cycles after the start edge, vec_count=4, err_count=0, pass=1.
//  3. Same setup, ALU_Out2[0] inverted on vector 2 only -> err_count=1, first_err=2, pass=0.
//  4. lockstep=0, ideal model, x forced to 4'h0 always -> errors only where Out1!=Out2.
//     err_count equals the model's count of differing vectors.
//  5. start re-pulsed mid-run -> ignored; wb_rst_n low mid-run -> immediate IDLE reset values.
//     Then start -> first vector operands again from SEED.
//  6. NUM_VEC=300, model with Out2 always inverted, lockstep=1 -> err_count=FF (saturated),
//     first_err=0, vec_count=300.

Source files
------------

// File: rtl/alu_lockstep_tester_if.sv
// alu_lockstep_tester_if: operand/select bus to the dual lockstep ALU and its result/compare bus back.
//  master (tester): drives A0,B0,A1,B1,ALU_Sel1,ALU_Sel2; reads ALU_Out1/2, CarryOut1/2, x, y
//  slave  (ALU)   : the mirror image
interface alu_lockstep_tester_if;
  logic [3:0] A0, B0, A1, B1;
  logic [1:0] ALU_Sel1, ALU_Sel2;
  logic [3:0] ALU_Out1, ALU_Out2;
  logic       CarryOut1, CarryOut2;
  logic [3:0] x;
  logic       y;
  modport master (
    output A0, B0, A1, B1, ALU_Sel1, ALU_Sel2,
    input  ALU_Out1, ALU_Out2, CarryOut1, CarryOut2, x, y
  );
  modport slave (
    input  A0, B0, A1, B1, ALU_Sel1, ALU_Sel2,
    output ALU_Out1, ALU_Out2, CarryOut1, CarryOut2, x, y
  );
endinterface

// File: rtl/alu_lockstep_tester.sv
// alu_lockstep_tester: LFSR-driven self-test of the dual 4-bit lockstep ALU with failure counting.
//  wb_clk_i, wb_rst_n (async, active-low), start, lockstep : control inputs
//  alu (master)                  : registered operands/selects out, ALU results and compare bus in
//  busy, done, pass              : run status (pass only ever with done)
//  err_count, first_err, vec_count : saturating fail count, index of first failure, vectors checked
module alu_lockstep_tester #(
  parameter logic [19:0] SEED     = 20'h5A5A5,
  parameter int          RESP_LAT = 2,
  parameter int          NUM_VEC  = 256
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n,
  input  logic                  start,
  input  logic                  lockstep,
  alu_lockstep_tester_if.master alu,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            err_count,
  output logic [15:0]           first_err,
  output logic [15:0]           vec_count
);
  // An all-zero LFSR would lock up, so a zero seed becomes 1.
  localparam logic [19:0] S       = (SEED == 20'h0) ? 20'h00001 : SEED;
  localparam logic [15:0] LAT_END = 16'(RESP_LAT - 1);
  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;
  state_t      state;
  logic [19:0] lfsr;
  logic [15:0] lat;
  logic        ls;
  logic        fail;
  logic        last;
  logic [7:0]  err_next;
  // Lockstep mode is latched with the operands so the check matches the vector that was driven.
  assign fail = (alu.x != (alu.ALU_Out1 ^ alu.ALU_Out2)) ||
                (alu.y != (alu.CarryOut1 ^ alu.CarryOut2)) ||
                (ls && (alu.ALU_Out1 != alu.ALU_Out2 || alu.CarryOut1 != alu.CarryOut2));
  assign err_next = (fail && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
  assign last = ({1'b0, vec_count} + 17'd1) >= 17'(NUM_VEC);
  always_ff @(posedge wb_clk_i or negedge wb_rst_n)
    if (!wb_rst_n) begin
      state        <= IDLE;
      lfsr         <= S;
      lat          <= '0;
      ls           <= 1'b0;
      alu.A0       <= '0;
      alu.B0       <= '0;
      alu.A1       <= '0;
      alu.B1       <= '0;
      alu.ALU_Sel1 <= '0;
      alu.ALU_Sel2 <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= '0;
      first_err    <= 16'hFFFF;
      vec_count    <= '0;
    end else
      case (state)
        IDLE, DONE:
          if (start) begin
            state     <= DRIVE;
            lfsr      <= S;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            first_err <= 16'hFFFF;
            vec_count <= '0;
          end
        DRIVE: begin
          alu.A0       <= lfsr[3:0];
          alu.B0       <= lfsr[7:4];
          alu.ALU_Sel1 <= lfsr[17:16];
          alu.A1       <= lockstep ? lfsr[3:0]   : lfsr[11:8];
          alu.B1       <= lockstep ? lfsr[7:4]   : lfsr[15:12];
          alu.ALU_Sel2 <= lockstep ? lfsr[17:16] : lfsr[19:18];
          ls           <= lockstep;
          lat          <= '0;
          state        <= WAIT;
        end
        WAIT: begin
          lat   <= lat + 16'd1;
          state <= (lat == LAT_END) ? CHECK : WAIT;
        end
        CHECK: begin
          vec_count <= vec_count + 16'd1;
          err_count <= err_next;
          lfsr      <= {lfsr[18:0], lfsr[19] ^ lfsr[16]};
          if (fail && first_err == 16'hFFFF) first_err <= vec_count;
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 8'd0);
          end else
            state <= DRIVE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_alu_lockstep_tester.sv
// tb_alu_lockstep_tester: scoreboard bench for two tester instances (short run, and long run with zero seed).
module tb_alu_lockstep_tester;
  localparam int          NV0 = 4;
  localparam int          NV1 = 300;
  localparam int          RL0 = 2;
  localparam int          RL1 = 1;
  localparam logic [19:0] SD0 = 20'h5A5A5;
  localparam logic [19:0] SD1 = 20'h00000;
  typedef struct packed {logic [3:0] a0, b0, a1, b1; logic [1:0] s1, s2;} ops_t;
  typedef struct packed {logic [7:0] err; logic [15:0] first, vec; logic pass;} res_t;
  typedef struct packed {logic [3:0] o1, o2; logic c1, c2; logic [3:0] x; logic y;} resp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  bit          clk_en = 1'b0;
  logic [1:0]  start, ls, busy, done, pass;
  logic [7:0]  errc[2];
  logic [15:0] ferr[2], vcnt[2];
  int          fmode[2], fvec[2], t0[2];
  ops_t        opq[2][$];
  res_t        resq[2][$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  initial begin
    wait (clk_en);
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int nv(input int g);
    return g == 0 ? NV0 : NV1;
  endfunction
  function automatic int rl(input int g);
    return g == 0 ? RL0 : RL1;
  endfunction
  function automatic logic [19:0] seed(input int g);
    logic [19:0] s;
    s = g == 0 ? SD0 : SD1;
    return s == 20'h0 ? 20'h00001 : s;
  endfunction
  // Behavioural ALU: {carry, result} for add, subtract (carry = borrow), and, xor.
  function automatic logic [4:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
    return s == 2'd0 ? {1'b0, a} + {1'b0, b} :
           s == 2'd1 ? {1'b0, a} - {1'b0, b} :
           s == 2'd2 ? {1'b0, a & b} : {1'b0, a ^ b};
  endfunction
  function automatic ops_t ops_of(input logic [19:0] l, input logic lk);
    ops_t o;
    o.a0 = l[3:0];
    o.b0 = l[7:4];
    o.s1 = l[17:16];
    o.a1 = lk ? l[3:0] : l[11:8];
    o.b1 = lk ? l[7:4] : l[15:12];
    o.s2 = lk ? l[17:16] : l[19:18];
    return o;
  endfunction
  // Dual ALU with fault injection: 1 flips Out2[0] on vector fv, 2 forces x=0, 3 inverts Out2.
  function automatic resp_t respond(input ops_t o, input int k, input int mode, input int fv);
    logic [4:0] r1, r2;
    resp_t r;
    r1 = alu(o.a0, o.b0, o.s1);
    r2 = alu(o.a1, o.b1, o.s2);
    r.o1 = r1[3:0];
    r.c1 = r1[4];
    r.o2 = r2[3:0];
    r.c2 = r2[4];
    if (mode == 1 && k == fv) r.o2[0] = ~r.o2[0];
    if (mode == 3) r.o2 = ~r.o2;
    r.x = mode == 2 ? 4'h0 : r.o1 ^ r.o2;
    r.y = r.c1 ^ r.c2;
    return r;
  endfunction
  function automatic bit fails(input resp_t r, input logic lk);
    return r.x != (r.o1 ^ r.o2) || r.y != (r.c1 ^ r.c2) || (lk && (r.o1 != r.o2 || r.c1 != r.c2));
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : u
    alu_lockstep_tester_if bus();
    resp_t r;
    ops_t  cur;
    alu_lockstep_tester #(
      .SEED(g == 0 ? SD0 : SD1), .RESP_LAT(g == 0 ? RL0 : RL1), .NUM_VEC(g == 0 ? NV0 : NV1)
    ) dut (
      .wb_clk_i(clk), .wb_rst_n(rst_n), .start(start[g]), .lockstep(ls[g]), .alu(bus),
      .busy(busy[g]), .done(done[g]), .pass(pass[g]),
      .err_count(errc[g]), .first_err(ferr[g]), .vec_count(vcnt[g])
    );
    assign cur = {bus.A0, bus.B0, bus.A1, bus.B1, bus.ALU_Sel1, bus.ALU_Sel2};
    assign r = respond(cur, int'(vcnt[g]), fmode[g], fvec[g]);
    assign bus.ALU_Out1  = r.o1;
    assign bus.ALU_Out2  = r.o2;
    assign bus.CarryOut1 = r.c1;
    assign bus.CarryOut2 = r.c2;
    assign bus.x         = r.x;
    assign bus.y         = r.y;
    // Monitor: a vec_count step means the operands still on the bus belong to the vector just checked.
    initial begin
      logic [15:0] pv;
      logic        pd;
      ops_t        e;
      res_t        er;
      pv = '0;
      pd = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          pv = '0;
          pd = 1'b0;
        end else begin
          if (vcnt[g] == pv + 16'd1) begin
            checks++;
            if (opq[g].size() == 0) begin
              errors++;
              $display("FAIL u%0d ops: unexpected vector %0d", g, vcnt[g]);
            end else begin
              e = opq[g].pop_front();
              if (cur !== e) begin
                errors++;
                $display("FAIL u%0d ops vec %0d: got %h expected %h", g, pv, cur, e);
              end
            end
          end
          if (done[g] && !pd) begin
            checks++;
            if (resq[g].size() == 0) begin
              errors++;
              $display("FAIL u%0d result: done without a pending run", g);
            end else begin
              er = resq[g].pop_front();
              if ({errc[g], ferr[g], vcnt[g], pass[g]} !== er) begin
                errors++;
                $display("FAIL u%0d result: got err=%0h first=%0h vec=%0d pass=%0b expected err=%0h first=%0h vec=%0d pass=%0b",
                         g, errc[g], ferr[g], vcnt[g], pass[g], er.err, er.first, er.vec, er.pass);
              end
            end
            checks++;
            if (opq[g].size() != 0) begin
              errors++;
              $display("FAIL u%0d leftover: got %0d unchecked vectors expected 0", g, opq[g].size());
            end
          end
          pv = vcnt[g];
          pd = done[g];
        end
      end
    end
  end
  task automatic prep(input int g, input logic lk, input int mode, input int fv);
    logic [19:0] l;
    int          e, f;
    ops_t        o;
    l = seed(g);
    e = 0;
    f = 16'hFFFF;
    for (int k = 0; k < nv(g); k++) begin
      o = ops_of(l, lk);
      opq[g].push_back(o);
      if (fails(respond(o, k, mode, fv), lk)) begin
        if (f == 16'hFFFF) f = k;
        if (e < 255) e++;
      end
      l = {l[18:0], l[19] ^ l[16]};
    end
    resq[g].push_back({8'(e), 16'(f), 16'(nv(g)), e == 0});
    @(negedge clk);
    fmode[g] = mode;
    fvec[g] = fv;
    ls[g] = lk;
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    t0[g] = cyc;
  endtask
  task automatic wait_done(input int g);
    int lim;
    lim = nv(g) * (rl(g) + 2) + 20;
    while (!done[g] && cyc - t0[g] < lim) @(negedge clk);
    chk($sformatf("u%0d latency", g), cyc - t0[g], nv(g) * (rl(g) + 2));
    repeat (2) @(negedge clk);
  endtask
  task automatic status_reset(input string tag);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s u%0d busy/done/pass", tag, g), {busy[g], done[g], pass[g]}, 0);
      chk($sformatf("%s u%0d err_count", tag, g), errc[g], 0);
      chk($sformatf("%s u%0d vec_count", tag, g), vcnt[g], 0);
      chk($sformatf("%s u%0d first_err", tag, g), ferr[g], 16'hFFFF);
    end
    chk({tag, " u0 operands"}, u[0].cur, 0);
    chk({tag, " u1 operands"}, u[1].cur, 0);
  endtask
  initial begin
    start = '0;
    ls = '0;
    fmode = '{0, 0};
    fvec = '{0, 0};
    t0 = '{0, 0};
    #1 rst_n = 1'b0;
    #2 status_reset("reset");
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prep(0, 1'b1, 0, 0);
    wait_done(0);
    chk("pass after ideal run", pass[0], 1);
    prep(0, 1'b1, 1, 2);
    wait_done(0);
    prep(0, 1'b0, 2, 0);
    wait_done(0);
    prep(0, 1'b1, 0, 0);
    repeat (6) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0);
    prep(0, 1'b1, 1, 1);
    repeat (15) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0);
    repeat (3) @(negedge clk);
    chk("start on final check: done held", done[0], 1);
    chk("start on final check: busy", busy[0], 0);
    chk("start on final check: vec_count", vcnt[0], NV0);
    prep(0, 1'b1, 3, 0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1 status_reset("midrun reset");
    opq[0].delete();
    resq[0].delete();
    @(negedge clk);
    rst_n = 1'b1;
    prep(0, 1'b1, 0, 0);
    wait_done(0);
    prep(1, 1'b1, 3, 0);
    wait_done(1);
    prep(1, 1'b0, 2, 0);
    wait_done(1);
    repeat (8) begin
      prep(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      wait_done(0);
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
